// File: rtl/operand_stack_if.sv
// Command, alu and status bundle between the decoder/alu environment and operand_stack.
// The slave modport is the stack side; master is the environment that drives commands.
interface operand_stack_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] alu_hi;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             err_over;
  logic             err_under;

  modport slave (
    input  cmd_valid, cmd, cmd_data, cmd_alu_op, alu_lo, alu_hi,
    output cmd_ready, alu_a, alu_b, alu_op, top, depth, err_over, err_under
  );

  modport master (
    output cmd_valid, cmd, cmd_data, cmd_alu_op, alu_lo, alu_hi,
    input  cmd_ready, alu_a, alu_b, alu_op, top, depth, err_over, err_under
  );
endinterface

// File: rtl/operand_stack.sv
// Operand stack and alu sequencer: executes decoder stack commands and routes operands
// and results through the downstream combinational alu, writing results back onto the stack.
module operand_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  operand_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] CMD_PUSH  = 3'd1;
  localparam logic [2:0] CMD_POP   = 3'd2;
  localparam logic [2:0] CMD_DUP   = 3'd3;
  localparam logic [2:0] CMD_SWAP  = 3'd4;
  localparam logic [2:0] CMD_UNOP  = 3'd5;
  localparam logic [2:0] CMD_BINOP = 3'd6;
  localparam logic [2:0] CMD_WIDE  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB_HI = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       kind_r, kind_nxt_s;
  logic [DW-1:0]    depth_r, depth_nxt_s;
  logic [WIDTH-1:0] alu_a_r, alu_a_nxt_s;
  logic [WIDTH-1:0] alu_b_r, alu_b_nxt_s;
  logic [3:0]       alu_op_r, alu_op_nxt_s;
  logic             err_over_r, err_over_nxt_s;
  logic             err_under_r, err_under_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             wa_en_s, wb_en_s;
  logic [AW-1:0]    wa_addr_s, wb_addr_s;
  logic [WIDTH-1:0] wa_data_s, wb_data_s;
  logic [AW-1:0]    idx_top_s, idx_sec_s, idx_free_s;
  logic [WIDTH-1:0] top_s, sec_s;
  logic             empty_s, full_s, has2_s;

  // Index arithmetic wraps only for slots that are never used when depth is out of range.
  assign idx_top_s  = AW'(depth_r - DW'(1));
  assign idx_sec_s  = AW'(depth_r - DW'(2));
  assign idx_free_s = AW'(depth_r);
  assign empty_s    = (depth_r == DW'(0));
  assign full_s     = (depth_r == DW'(DEPTH));
  assign has2_s     = (depth_r >= DW'(2));
  assign top_s      = mem_r[idx_top_s];
  assign sec_s      = mem_r[idx_sec_s];

  assign bus.cmd_ready = (state_r == ST_IDLE);
  assign bus.top       = empty_s ? {WIDTH{1'b0}} : top_s;
  assign bus.depth     = depth_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.err_over  = err_over_r;
  assign bus.err_under = err_under_r;

  // Next-state, stack write ports and operand latching
  always_comb begin
    state_nxt_s     = state_r;
    kind_nxt_s      = kind_r;
    depth_nxt_s     = depth_r;
    alu_a_nxt_s     = alu_a_r;
    alu_b_nxt_s     = alu_b_r;
    alu_op_nxt_s    = alu_op_r;
    err_over_nxt_s  = err_over_r;
    err_under_nxt_s = err_under_r;
    wa_en_s         = 1'b0;
    wa_addr_s       = {AW{1'b0}};
    wa_data_s       = {WIDTH{1'b0}};
    wb_en_s         = 1'b0;
    wb_addr_s       = {AW{1'b0}};
    wb_data_s       = {WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            CMD_PUSH: begin
              if (!full_s) begin
                wa_en_s     = 1'b1;
                wa_addr_s   = idx_free_s;
                wa_data_s   = bus.cmd_data;
                depth_nxt_s = depth_r + DW'(1);
              end else begin
                err_over_nxt_s = 1'b1;
              end
            end
            CMD_POP: begin
              if (!empty_s) begin
                depth_nxt_s = depth_r - DW'(1);
              end else begin
                err_under_nxt_s = 1'b1;
              end
            end
            CMD_DUP: begin
              if (empty_s) begin
                err_under_nxt_s = 1'b1;
              end else if (full_s) begin
                err_over_nxt_s = 1'b1;
              end else begin
                wa_en_s     = 1'b1;
                wa_addr_s   = idx_free_s;
                wa_data_s   = top_s;
                depth_nxt_s = depth_r + DW'(1);
              end
            end
            CMD_SWAP: begin
              if (has2_s) begin
                wa_en_s   = 1'b1;
                wa_addr_s = idx_top_s;
                wa_data_s = sec_s;
                wb_en_s   = 1'b1;
                wb_addr_s = idx_sec_s;
                wb_data_s = top_s;
              end else begin
                err_under_nxt_s = 1'b1;
              end
            end
            CMD_UNOP: begin
              if (!empty_s) begin
                alu_a_nxt_s  = top_s;
                alu_b_nxt_s  = bus.cmd_data;
                alu_op_nxt_s = bus.cmd_alu_op;
                kind_nxt_s   = bus.cmd;
                state_nxt_s  = ST_EXEC;
              end else begin
                err_under_nxt_s = 1'b1;
              end
            end
            CMD_BINOP, CMD_WIDE: begin
              if (has2_s) begin
                alu_a_nxt_s  = sec_s;
                alu_b_nxt_s  = top_s;
                alu_op_nxt_s = bus.cmd_alu_op;
                kind_nxt_s   = bus.cmd;
                state_nxt_s  = ST_EXEC;
              end else begin
                err_under_nxt_s = 1'b1;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wa_en_s   = 1'b1;
        wa_data_s = bus.alu_lo;
        case (kind_r)
          CMD_UNOP: begin
            wa_addr_s   = idx_top_s;
            state_nxt_s = ST_IDLE;
          end
          CMD_BINOP: begin
            wa_addr_s   = idx_sec_s;
            depth_nxt_s = depth_r - DW'(1);
            state_nxt_s = ST_IDLE;
          end
          CMD_WIDE: begin
            wa_addr_s   = idx_sec_s;
            state_nxt_s = ST_WB_HI;
          end
          default: begin
            wa_en_s     = 1'b0;
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
      ST_WB_HI: begin
        wa_en_s     = 1'b1;
        wa_addr_s   = idx_top_s;
        wa_data_s   = bus.alu_hi;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      kind_r      <= 3'd0;
      depth_r     <= {DW{1'b0}};
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= 4'd0;
      err_over_r  <= 1'b0;
      err_under_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      kind_r      <= kind_nxt_s;
      depth_r     <= depth_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      alu_op_r    <= alu_op_nxt_s;
      err_over_r  <= err_over_nxt_s;
      err_under_r <= err_under_nxt_s;
    end
  end

  // Stack storage is not reset; writes are suppressed while rst is held so an aborted op leaves no trace
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wa_en_s) begin
        mem_r[wa_addr_s] <= wa_data_s;
      end
      if (wb_en_s) begin
        mem_r[wb_addr_s] <= wb_data_s;
      end
    end
  end
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: queue-based stack model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_operand_stack;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_PUSH  = 3'd1;
  localparam logic [2:0] C_POP   = 3'd2;
  localparam logic [2:0] C_DUP   = 3'd3;
  localparam logic [2:0] C_SWAP  = 3'd4;
  localparam logic [2:0] C_UNOP  = 3'd5;
  localparam logic [2:0] C_BINOP = 3'd6;
  localparam logic [2:0] C_WIDE  = 3'd7;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  operand_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  operand_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational alu stand-in: {hi, lo}
  function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'h0, 4'h1: alu_fn = {32'h0, a + b};
      4'h2:       alu_fn = {32'h0, a - b};
      4'h3:       alu_fn = 64'(a) * 64'(b);
      4'h6:       alu_fn = {32'h0, a & b};
      4'hF:       alu_fn = {32'h0000_000B, 32'h0000_000A};
      default:    alu_fn = {32'h0, a ^ b};
    endcase
  endfunction

  assign {bus.alu_hi, bus.alu_lo} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: stack as a queue, alu ops as pending writebacks
  logic [31:0] m_stk [$];
  int          m_busy;
  logic [2:0]  m_kind;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic        m_eov, m_eun;
  bit          started;

  initial begin
    logic [63:0] r;
    int n;
    started = 1'b0;
    m_busy = 0; m_kind = 3'd0; m_a = 32'h0; m_b = 32'h0; m_op = 4'h0;
    m_eov = 1'b0; m_eun = 1'b0;
    forever begin
      @(posedge clk);
      n = m_stk.size();
      if (rst) begin
        m_stk.delete();
        m_busy = 0; m_a = 32'h0; m_b = 32'h0; m_op = 4'h0;
        m_eov = 1'b0; m_eun = 1'b0;
        started = 1'b1;
      end else if (m_busy > 0) begin
        r = alu_fn(m_a, m_b, m_op);
        if (m_kind == C_UNOP) begin
          m_stk[n-1] = r[31:0];
        end else if (m_kind == C_BINOP) begin
          m_stk[n-2] = r[31:0];
          void'(m_stk.pop_back());
        end else if (m_busy == 2) begin
          m_stk[n-2] = r[31:0];
        end else begin
          m_stk[n-1] = r[63:32];
        end
        m_busy--;
      end else if (bus.cmd_valid) begin
        case (bus.cmd)
          C_PUSH: if (n < DEPTH) m_stk.push_back(bus.cmd_data); else m_eov = 1'b1;
          C_POP:  if (n >= 1) void'(m_stk.pop_back()); else m_eun = 1'b1;
          C_DUP: begin
            if (n == 0) m_eun = 1'b1;
            else if (n == DEPTH) m_eov = 1'b1;
            else m_stk.push_back(m_stk[n-1]);
          end
          C_SWAP: begin
            if (n >= 2) begin
              r[31:0] = m_stk[n-1];
              m_stk[n-1] = m_stk[n-2];
              m_stk[n-2] = r[31:0];
            end else m_eun = 1'b1;
          end
          C_UNOP: begin
            if (n >= 1) begin
              m_a = m_stk[n-1]; m_b = bus.cmd_data; m_op = bus.cmd_alu_op;
              m_kind = C_UNOP; m_busy = 1;
            end else m_eun = 1'b1;
          end
          C_BINOP, C_WIDE: begin
            if (n >= 2) begin
              m_a = m_stk[n-2]; m_b = m_stk[n-1]; m_op = bus.cmd_alu_op;
              m_kind = bus.cmd; m_busy = (bus.cmd == C_WIDE) ? 2 : 1;
            end else m_eun = 1'b1;
          end
          default: ;
        endcase
      end
      #1;
      if (started) begin
        n = m_stk.size();
        chk("m_ready", bus.cmd_ready, (m_busy == 0));
        chk("m_depth", bus.depth, n);
        chk("m_top", bus.top, (n == 0) ? 32'h0 : m_stk[n-1]);
        chk("m_alu_a", bus.alu_a, m_a);
        chk("m_alu_b", bus.alu_b, m_b);
        chk("m_alu_op", bus.alu_op, m_op);
        chk("m_err_over", bus.err_over, m_eov);
        chk("m_err_under", bus.err_under, m_eun);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] d, input logic [3:0] op);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 8) begin
      tick();
      n++;
    end
    chk("ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_valid  = 1'b1;
    bus.cmd        = c;
    bus.cmd_data   = d;
    bus.cmd_alu_op = op;
    tick();
    bus.cmd_valid  = 1'b0;
    bus.cmd        = C_NOP;
    bus.cmd_data   = 32'h0;
    bus.cmd_alu_op = 4'h0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd = C_NOP; bus.cmd_data = 32'h0; bus.cmd_alu_op = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_depth", bus.depth, 0);
    chk("rst_top", bus.top, 32'h0);
    chk("rst_alu_a", bus.alu_a, 32'h0);
    chk("rst_errs", {bus.err_over, bus.err_under}, 2'b00);

    // BINOP add
    issue(C_PUSH, 32'hFF, 4'h0);
    issue(C_PUSH, 32'hFF, 4'h0);
    issue(C_BINOP, 32'h0, 4'h1);
    chk("t1_alu_a", bus.alu_a, 32'hFF);
    chk("t1_alu_b", bus.alu_b, 32'hFF);
    chk("t1_alu_op", bus.alu_op, 4'h1);
    tick();
    chk("t1_top", bus.top, 32'h1FE);
    chk("t1_depth", bus.depth, 1);

    // UNOP increment
    do_reset();
    issue(C_PUSH, 32'hFF, 4'h0);
    issue(C_UNOP, 32'h1, 4'h0);
    chk("t2_busy", bus.cmd_ready, 1'b0);
    tick();
    chk("t2_ready", bus.cmd_ready, 1'b1);
    chk("t2_top", bus.top, 32'h100);
    chk("t2_depth", bus.depth, 1);

    // SWAP then AND
    do_reset();
    issue(C_PUSH, 32'hF0, 4'h0);
    issue(C_PUSH, 32'h3C, 4'h0);
    issue(C_SWAP, 32'h0, 4'h0);
    chk("t3_swap_top", bus.top, 32'hF0);
    issue(C_BINOP, 32'h0, 4'h6);
    chk("t3_alu_a", bus.alu_a, 32'h3C);
    chk("t3_alu_b", bus.alu_b, 32'hF0);
    tick();
    chk("t3_top", bus.top, 32'h30);

    // BINOP_WIDE with constant stub
    do_reset();
    issue(C_PUSH, 32'h1, 4'h0);
    issue(C_PUSH, 32'h2, 4'h0);
    issue(C_WIDE, 32'h0, 4'hF);
    chk("t4_busy0", bus.cmd_ready, 1'b0);
    tick();
    chk("t4_busy1", bus.cmd_ready, 1'b0);
    tick();
    chk("t4_ready", bus.cmd_ready, 1'b1);
    chk("t4_depth", bus.depth, 2);
    chk("t4_top", bus.top, 32'hB);
    issue(C_POP, 32'h0, 4'h0);
    chk("t4_second", bus.top, 32'hA);

    // BINOP_WIDE multiply with a real high half
    do_reset();
    issue(C_PUSH, 32'hFFFF_FFFF, 4'h0);
    issue(C_PUSH, 32'h2, 4'h0);
    issue(C_WIDE, 32'h0, 4'h3);
    tick();
    tick();
    chk("tm_hi", bus.top, 32'h1);
    issue(C_POP, 32'h0, 4'h0);
    chk("tm_lo", bus.top, 32'hFFFF_FFFE);

    // Fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(C_PUSH, 32'(i + 1), 4'h0);
    chk("t5_full_depth", bus.depth, DEPTH);
    chk("t5_full_top", bus.top, 32'(DEPTH));
    chk("t5_no_over", bus.err_over, 1'b0);
    issue(C_PUSH, 32'h5, 4'h0);
    chk("t5_over", bus.err_over, 1'b1);
    chk("t5_over_depth", bus.depth, DEPTH);
    chk("t5_over_top", bus.top, 32'(DEPTH));
    issue(C_DUP, 32'h0, 4'h0);
    chk("t5_dup_full", bus.depth, DEPTH);

    // Pop to empty, then underflow
    do_reset();
    issue(C_PUSH, 32'h7, 4'h0);
    issue(C_POP, 32'h0, 4'h0);
    chk("t5_pop_top", bus.top, 32'h0);
    chk("t5_pop_depth", bus.depth, 0);
    chk("t5_no_under", bus.err_under, 1'b0);
    issue(C_POP, 32'h0, 4'h0);
    chk("t5_under", bus.err_under, 1'b1);
    chk("t5_under_depth", bus.depth, 0);
    issue(C_PUSH, 32'h4, 4'h0);
    issue(C_BINOP, 32'h0, 4'h0);
    chk("t5_binop_short", bus.cmd_ready, 1'b1);
    issue(C_DUP, 32'h0, 4'h0);
    issue(C_SWAP, 32'h0, 4'h0);
    chk("t5_dup_swap_top", bus.top, 32'h4);
    chk("t5_dup_swap_depth", bus.depth, 2);

    // Reset during EXEC
    do_reset();
    issue(C_PUSH, 32'h3, 4'h0);
    issue(C_PUSH, 32'h4, 4'h0);
    issue(C_BINOP, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    chk("t6_depth", bus.depth, 0);
    chk("t6_ready", bus.cmd_ready, 1'b1);
    chk("t6_alu", {bus.alu_a, bus.alu_b}, 64'h0);
    chk("t6_alu_op", bus.alu_op, 4'h0);
    rst = 1'b0;
    issue(C_PUSH, 32'h9, 4'h0);
    chk("t6_push_top", bus.top, 32'h9);
    chk("t6_push_depth", bus.depth, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
